// File: rtl/dit_frame_scheduler.sv
// MT-32 DAC bus to I2S frame scheduler: strobe sync, CD4051 sequence tracking,
// L/R mixing with saturation, frame FIFO and a one-entry prefetch for the serializer.
module dit_frame_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int LOCK_FRAMES = 2,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic                          clk_inh,
    input  logic [2:0]                    ch_id,
    input  logic [15:0]                   dac,
    input  logic                          rev_sw,
    input  logic                          drq,
    output logic [31:0]                   data,
    output logic                          dtr,
    output logic                          locked,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          seq_err,
    output logic                          overrun,
    output logic                          underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]  LOCK_CNT  = 8'(LOCK_FRAMES);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic        inh_s1, inh_s2, inh_s3;
    logic        stb;

    logic [15:0] lrev, rrev, lsyn2, lsyn1, rsyn2, rsyn1;

    logic [1:0]  state;
    logic [2:0]  exp_ch;
    logic [7:0]  good;
    logic        mix_go;

    logic        go_d;
    logic        sum_vld;
    logic [17:0] sum_l, sum_r;
    logic [31:0] mix_frame;
    logic        push_req;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    logic          drq_q;
    logic          drq_edge;

    function automatic logic [2:0] next_ch(input logic [2:0] c);
        case (c)
            3'd4:    return 3'd0;
            3'd0:    return 3'd6;
            3'd6:    return 3'd2;
            3'd2:    return 3'd5;
            3'd5:    return 3'd1;
            3'd1:    return 3'd7;
            3'd7:    return 3'd3;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [17:0] sx(input logic [15:0] v);
        return {{2{v[15]}}, v};
    endfunction

    // An 18-bit sum is in 16-bit range only when bits 17..15 agree.
    function automatic logic [15:0] clamp16(input logic [17:0] s);
        if (!SATURATE)
            return s[15:0];
        if (!s[17] && (s[16] || s[15]))
            return 16'h7FFF;
        if (s[17] && !(s[16] && s[15]))
            return 16'h8000;
        return s[15:0];
    endfunction

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            inh_s1 <= 1'b0;
            inh_s2 <= 1'b0;
            inh_s3 <= 1'b0;
        end else begin
            inh_s1 <= clk_inh;
            inh_s2 <= inh_s1;
            inh_s3 <= inh_s2;
        end
    end

    assign stb = inh_s3 & ~inh_s2;

    // Channel capture runs regardless of lock state so the mix always sees fresh data.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            lrev  <= '0;
            rrev  <= '0;
            lsyn2 <= '0;
            lsyn1 <= '0;
            rsyn2 <= '0;
            rsyn1 <= '0;
        end else if (stb) begin
            case (ch_id)
                3'd0:    lrev  <= dac;
                3'd1:    rrev  <= dac;
                3'd2:    lsyn2 <= dac;
                3'd3:    lsyn1 <= dac;
                3'd6:    rsyn2 <= dac;
                3'd7:    rsyn1 <= dac;
                default: ;
            endcase
        end
    end

    assign mix_go = stb && (state != ST_HUNT) && (ch_id == exp_ch) && (ch_id == 3'd3);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state   <= ST_HUNT;
            exp_ch  <= 3'd4;
            good    <= '0;
            seq_err <= 1'b0;
        end else begin
            seq_err <= 1'b0;
            if (stb) begin
                case (state)
                    ST_HUNT: begin
                        if (ch_id == 3'd3) begin
                            state  <= ST_ALIGN;
                            exp_ch <= 3'd4;
                            good   <= '0;
                        end
                    end
                    default: begin
                        if (ch_id == exp_ch) begin
                            exp_ch <= next_ch(exp_ch);
                            if (state == ST_ALIGN && ch_id == 3'd3) begin
                                good <= good + 8'd1;
                                if (good + 8'd1 == LOCK_CNT)
                                    state <= ST_LOCKED;
                            end
                        end else begin
                            state   <= ST_HUNT;
                            seq_err <= (state == ST_LOCKED);
                        end
                    end
                endcase
            end
        end
    end

    assign locked = (state == ST_LOCKED);

    // Two-stage mix: sums one cycle after the ch 3 strobe, clamp and push the cycle after.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            go_d    <= 1'b0;
            sum_vld <= 1'b0;
            sum_l   <= '0;
            sum_r   <= '0;
        end else begin
            go_d    <= mix_go;
            sum_vld <= go_d;
            if (go_d) begin
                if (rev_sw) begin
                    sum_l <= sx(lsyn1) + sx(lrev) + sx(lsyn2);
                    sum_r <= sx(rsyn1) + sx(rrev) + sx(rsyn2);
                end else begin
                    sum_l <= sx(lsyn1);
                    sum_r <= sx(rsyn1);
                end
            end
        end
    end

    assign mix_frame = {clamp16(sum_l), clamp16(sum_r)};
    assign push_req  = sum_vld && locked;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign drq_edge   = drq & ~drq_q;
    assign pop        = !fifo_empty && (!dtr || drq_edge);
    assign push       = push_req && (!fifo_full || pop);

    always_ff @(posedge mclk) begin
        if (push)
            mem[wr_ptr] <= mix_frame;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && fifo_full && !pop;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    assign fifo_level = count;

    // Prefetch register: reloads on the consuming drq edge when the FIFO has a frame.
    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            drq_q    <= 1'b0;
            dtr      <= 1'b0;
            data     <= '0;
            underrun <= 1'b0;
        end else begin
            drq_q    <= drq;
            underrun <= drq_edge && !dtr;
            if (pop) begin
                data <= mem[rd_ptr];
                dtr  <= 1'b1;
            end else if (drq_edge && dtr) begin
                dtr  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dit_frame_scheduler.sv
// Scoreboard bench for dit_frame_scheduler: directed frames queue expected words,
// a negedge monitor compares each frame as the serializer consumes it.
module tb_dit_frame_scheduler;

    logic        mclk = 1'b0;
    logic        rst = 1'b0;
    logic        clk_inh = 1'b0;
    logic [2:0]  ch_id = 3'd0;
    logic [15:0] dac = 16'd0;
    logic        rev_sw = 1'b0;
    logic        drq = 1'b0;

    logic [31:0] data, data_w;
    logic        dtr, dtr_w;
    logic        locked, locked_w;
    logic [2:0]  fifo_level, fifo_level_w;
    logic        seq_err, seq_err_w;
    logic        overrun, overrun_w;
    logic        underrun, underrun_w;

    int checks = 0;
    int errors = 0;
    int n_seq_err = 0;
    int n_overrun = 0;
    int n_underrun = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    logic        drq_seen = 1'b0;

    logic [31:0] t4_exp [5] = '{32'h0001FFFF, 32'h0002FFFE, 32'h0003FFFD,
                                32'h0004FFFC, 32'h0005FFFB};

    dit_frame_scheduler #(.FIFO_DEPTH(4), .LOCK_FRAMES(2), .SATURATE(1'b1)) dut (
        .mclk(mclk), .rst(rst), .clk_inh(clk_inh), .ch_id(ch_id), .dac(dac),
        .rev_sw(rev_sw), .drq(drq), .data(data), .dtr(dtr), .locked(locked),
        .fifo_level(fifo_level), .seq_err(seq_err), .overrun(overrun),
        .underrun(underrun)
    );

    dit_frame_scheduler #(.FIFO_DEPTH(4), .LOCK_FRAMES(2), .SATURATE(1'b0)) dut_w (
        .mclk(mclk), .rst(rst), .clk_inh(clk_inh), .ch_id(ch_id), .dac(dac),
        .rev_sw(rev_sw), .drq(drq), .data(data_w), .dtr(dtr_w), .locked(locked_w),
        .fifo_level(fifo_level_w), .seq_err(seq_err_w), .overrun(overrun_w),
        .underrun(underrun_w)
    );

    always #5 mclk = ~mclk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One CD4051 slot: bus stable for the whole slot, INH falls halfway through.
    task automatic applyStimulus(input logic [2:0] ch, input logic [15:0] val);
        @(posedge mclk); #1;
        ch_id   = ch;
        dac     = val;
        clk_inh = 1'b1;
        repeat (8) @(posedge mclk);
        #1 clk_inh = 1'b0;
        repeat (8) @(posedge mclk);
    endtask

    task automatic send_frame(input logic rev, input logic [15:0] lrev, input logic [15:0] rrev,
                              input logic [15:0] lsyn2, input logic [15:0] lsyn1,
                              input logic [15:0] rsyn2, input logic [15:0] rsyn1,
                              input logic push_exp, input logic [31:0] exp_frame,
                              input logic [2:0] slot5_ch);
        rev_sw = rev;
        if (push_exp)
            exp_q.push_back(exp_frame);
        applyStimulus(3'd4, 16'd0);
        applyStimulus(3'd0, lrev);
        applyStimulus(3'd6, rsyn2);
        applyStimulus(3'd2, lsyn2);
        applyStimulus(slot5_ch, 16'd0);
        applyStimulus(3'd1, rrev);
        applyStimulus(3'd7, rsyn1);
        applyStimulus(3'd3, lsyn1);
        repeat (4) @(posedge mclk);
        #2;
    endtask

    task automatic simple_frame(input logic [15:0] l, input logic [15:0] r,
                                input logic push_exp, input logic [31:0] exp_frame);
        send_frame(1'b0, 16'd0, 16'd0, 16'd0, l, 16'd0, r, push_exp, exp_frame, 3'd5);
    endtask

    task automatic pulse_drq();
        @(posedge mclk); #1 drq = 1'b1;
        repeat (3) @(posedge mclk);
        #1 drq = 1'b0;
        repeat (3) @(posedge mclk);
        #2;
    endtask

    // Monitor: a rising drq seen at negedge is consumed at the next posedge.
    always @(negedge mclk) begin
        if (!rst) begin
            if (seq_err)  n_seq_err++;
            if (overrun)  n_overrun++;
            if (underrun) n_underrun++;
        end
        if (drq && !drq_seen && dtr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame: got %h, expected no frame", data);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("frame", data, mon_exp);
            end
        end
        drq_seen = drq;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge mclk);
        #2;
        checkOutput("rst_data", data, 32'h0);
        checkOutput("rst_dtr", {31'd0, dtr}, 32'd0);
        checkOutput("rst_locked", {31'd0, locked}, 32'd0);
        checkOutput("rst_level", {29'd0, fifo_level}, 32'd0);
        checkOutput("rst_pulses", {29'd0, seq_err, overrun, underrun}, 32'd0);
        @(posedge mclk); #1 rst = 1'b0;

        $display("[TB] clean sequence, rev_sw=0");
        simple_frame(16'd100, -16'sd50, 1'b0, 32'h0);
        checkOutput("t1_unlocked_f1", {31'd0, locked}, 32'd0);
        simple_frame(16'd100, -16'sd50, 1'b0, 32'h0);
        checkOutput("t1_unlocked_f2", {31'd0, locked}, 32'd0);
        checkOutput("t1_no_frame", {31'd0, dtr}, 32'd0);
        simple_frame(16'd100, -16'sd50, 1'b1, 32'h0064FFCE);
        checkOutput("t1_locked_f3", {31'd0, locked}, 32'd1);
        checkOutput("t1_dtr", {31'd0, dtr}, 32'd1);
        checkOutput("t1_data", data, 32'h0064FFCE);
        simple_frame(16'd100, -16'sd50, 1'b1, 32'h0064FFCE);
        checkOutput("t1_level", {29'd0, fifo_level}, 32'd1);
        pulse_drq();
        pulse_drq();
        checkOutput("t1_drained_dtr", {31'd0, dtr}, 32'd0);

        $display("[TB] reverb mix and saturation");
        send_frame(1'b1, 16'd20000, -16'sd20000, 16'd20000, 16'd20000, -16'sd20000,
                   -16'sd20000, 1'b1, 32'h7FFF8000, 3'd5);
        checkOutput("t2_sat_data", data, 32'h7FFF8000);
        checkOutput("t2_wrap_data", data_w, 32'hEA6015A0);
        checkOutput("t2_wrap_dtr", {31'd0, dtr_w}, 32'd1);
        pulse_drq();
        send_frame(1'b1, 16'd1000, -16'sd1, 16'd200, 16'd30, -16'sd2, -16'sd3,
                   1'b1, 32'h04CEFFFA, 3'd5);
        send_frame(1'b1, 16'd20000, -16'sd20000, 16'd2767, 16'd10000, -16'sd2769,
                   -16'sd10000, 1'b1, 32'h7FFF8000, 3'd5);
        send_frame(1'b1, -16'sd20000, 16'd20000, -16'sd2768, -16'sd10000, 16'd2768,
                   16'd10000, 1'b1, 32'h80007FFF, 3'd5);
        send_frame(1'b0, 16'd500, 16'd9, 16'd7, -16'sd1, 16'd9, 16'd32767,
                   1'b1, 32'hFFFF7FFF, 3'd5);
        repeat (4) pulse_drq();

        $display("[TB] sequence error while locked");
        send_frame(1'b0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd2, 1'b0, 32'h0, 3'd1);
        checkOutput("t3_seq_err", n_seq_err, 32'd1);
        checkOutput("t3_unlocked", {31'd0, locked}, 32'd0);
        checkOutput("t3_no_push", {29'd0, fifo_level, dtr}, 32'd0);
        simple_frame(16'd1, 16'd2, 1'b0, 32'h0);
        checkOutput("t3_still_unlocked", {31'd0, locked}, 32'd0);
        simple_frame(16'd1, 16'd2, 1'b1, 32'h00010002);
        checkOutput("t3_relocked", {31'd0, locked}, 32'd1);
        pulse_drq();

        $display("[TB] FIFO fill without drq");
        for (int k = 1; k <= 7; k++)
            simple_frame(16'(k), 16'(-k), k <= 5, (k <= 5) ? t4_exp[k-1] : 32'h0);
        checkOutput("t4_level", {29'd0, fifo_level}, 32'd4);
        checkOutput("t4_overrun", n_overrun, 32'd2);
        checkOutput("t4_dtr", {31'd0, dtr}, 32'd1);
        repeat (5) pulse_drq();

        $display("[TB] drq with no frames");
        checkOutput("t5_underrun_before", n_underrun, 32'd0);
        repeat (3) pulse_drq();
        checkOutput("t5_underrun", n_underrun, 32'd3);
        checkOutput("t5_dtr", {31'd0, dtr}, 32'd0);
        checkOutput("t5_data_held", data, 32'h0005FFFB);

        $display("[TB] reset mid-sequence");
        simple_frame(16'd7, 16'd8, 1'b1, 32'h00070008);
        simple_frame(16'd7, 16'd8, 1'b1, 32'h00070008);
        checkOutput("t6_queued", {29'd0, fifo_level}, 32'd1);
        applyStimulus(3'd4, 16'd0);
        applyStimulus(3'd0, 16'd3);
        #1 rst = 1'b1;
        #1;
        checkOutput("t6_rst_data", data, 32'h0);
        checkOutput("t6_rst_flags", {28'd0, dtr, locked, overrun, underrun}, 32'd0);
        checkOutput("t6_rst_level", {29'd0, fifo_level}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge mclk);
        #1 rst = 1'b0;
        simple_frame(16'h1234, 16'h5678, 1'b0, 32'h0);
        checkOutput("t6_unlocked_1", {31'd0, locked}, 32'd0);
        simple_frame(16'h1234, 16'h5678, 1'b0, 32'h0);
        checkOutput("t6_unlocked_2", {31'd0, locked}, 32'd0);
        checkOutput("t6_empty", {29'd0, fifo_level}, 32'd0);
        simple_frame(16'h1234, 16'h5678, 1'b1, 32'h12345678);
        checkOutput("t6_relocked", {31'd0, locked}, 32'd1);
        pulse_drq();

        checkOutput("end_scoreboard_left", exp_q.size(), 32'd0);
        checkOutput("end_seq_err", n_seq_err, 32'd1);
        checkOutput("end_overrun", n_overrun, 32'd2);
        checkOutput("end_underrun", n_underrun, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
